// File: rtl/inc_rr_arbiter.sv
// Round-robin sequencer that time-shares one external INC datapath among NREQ requesters.
// Optional build macro INC_ARB_SAT_EN: saturate d to all-ones on overflow instead of wrapping.
module inc_rr_arbiter #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned NREQ      = 4,
    parameter int unsigned IDW       = $clog2(NREQ)
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DATAWIDTH-1:0] a_flat,
    output logic [NREQ-1:0]           gnt,
    output logic [DATAWIDTH-1:0]      inc_a,
    input  logic [DATAWIDTH-1:0]      inc_d,
    output logic [DATAWIDTH-1:0]      d,
    output logic                      d_valid,
    output logic [IDW-1:0]            d_id,
    output logic                      ovf,
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NREQ-1:0]        gnt_q, gnt_d;
    logic [DATAWIDTH-1:0]   inc_a_q, inc_a_d;
    logic [DATAWIDTH-1:0]   d_q, d_d;
    logic                   d_valid_q, d_valid_d;
    logic [IDW-1:0]         d_id_q, d_id_d;
    logic                   ovf_q, ovf_d;
    logic [IDW-1:0]         ptr_q, ptr_d;

    logic [IDW-1:0]         win;
    logic                   hit;
    int unsigned            idx;

    // First asserted request at or after ptr, wrapping modulo NREQ.
    always_comb begin
        win = '0;
        hit = 1'b0;
        idx = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr_q) + k) % NREQ;
            if (!hit && req[idx[IDW-1:0]]) begin
                hit = 1'b1;
                win = idx[IDW-1:0];
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            inc_a_q   <= '0;
            d_q       <= '0;
            d_valid_q <= 1'b0;
            d_id_q    <= '0;
            ovf_q     <= 1'b0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            inc_a_q   <= inc_a_d;
            d_q       <= d_d;
            d_valid_q <= d_valid_d;
            d_id_q    <= d_id_d;
            ovf_q     <= ovf_d;
            ptr_q     <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|req) state_d = ISSUE;
            ISSUE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d     = gnt_q;
        inc_a_d   = inc_a_q;
        d_d       = d_q;
        d_valid_d = d_valid_q;
        d_id_d    = d_id_q;
        ovf_d     = ovf_q;
        ptr_d     = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    gnt_d   = '0;
                    gnt_d[win] = 1'b1;
                    inc_a_d = a_flat[win*DATAWIDTH +: DATAWIDTH];
                    d_id_d  = win;
                end
            end
            ISSUE: begin
                ovf_d     = &inc_a_q;
                d_valid_d = 1'b1;
`ifdef INC_ARB_SAT_EN
                d_d       = (&inc_a_q) ? '1 : inc_d;
`else
                d_d       = inc_d;
`endif
            end
            DONE: begin
                gnt_d     = '0;
                d_valid_d = 1'b0;
                ptr_d     = (d_id_q == IDW'(NREQ - 1)) ? '0 : d_id_q + 1'b1;
            end
            default: ;
        endcase
    end

    assign gnt     = gnt_q;
    assign inc_a   = inc_a_q;
    assign d       = d_q;
    assign d_valid = d_valid_q;
    assign d_id    = d_id_q;
    assign ovf     = ovf_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_inc_rr_arbiter.sv
// Randomized self-checking bench for inc_rr_arbiter against a transaction-level round-robin model.
module tb_inc_rr_arbiter;

    localparam int DW   = 32;
    localparam int NREQ = 4;

    logic              Clk;
    logic              Rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*DW-1:0] a_flat;
    logic [NREQ-1:0]   gnt;
    logic [DW-1:0]     inc_a;
    logic [DW-1:0]     inc_d;
    logic [DW-1:0]     d;
    logic              d_valid;
    logic [1:0]        d_id;
    logic              ovf;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;
    int m_ptr   = 0;

    inc_rr_arbiter #(.DATAWIDTH(DW), .NREQ(NREQ), .IDW(2)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .req(req), .a_flat(a_flat), .gnt(gnt),
        .inc_a(inc_a), .inc_d(inc_d), .d(d), .d_valid(d_valid), .d_id(d_id),
        .ovf(ovf), .busy(busy)
    );

    // Stand-in for the shared INC block.
    assign inc_d = inc_a + 32'd1;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Visit requesters in service order starting at p; first requesting one wins.
    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        int order[$];
        for (int k = 0; k < NREQ; k++) order.push_back((p + k) % NREQ);
        foreach (order[i]) if (r[order[i]]) return order[i];
        return -1;
    endfunction

    function automatic logic [DW-1:0] expect_d(input logic [DW-1:0] op);
`ifdef INC_ARB_SAT_EN
        if (op == 32'hFFFF_FFFF) return 32'hFFFF_FFFF;
`endif
        return op + 32'd1;
    endfunction

    // Runs one full operation; req must be nonzero and the DUT idle on entry.
    // mode 0: hold inputs, 1: scramble req/operands in ISSUE, 2: set a0=9 in ISSUE.
    task automatic run_op(input int mode, output int w);
        logic [DW-1:0] op;
        w  = pick(req, m_ptr);
        op = a_flat[w*DW +: DW];
        @(posedge Clk); #1;
        check("gnt", 64'(gnt), 64'(1 << w));
        check("busy_issue", 64'(busy), 64'd1);
        check("inc_a", 64'(inc_a), 64'(op));
        check("d_id_gnt", 64'(d_id), 64'(w));
        check("dv_issue", 64'(d_valid), 64'd0);
        if (mode == 1) begin
            req = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) a_flat[i*DW +: DW] = $urandom;
        end else if (mode == 2) begin
            a_flat[0 +: DW] = 32'd9;
        end
        @(posedge Clk); #1;
        check("dv_done", 64'(d_valid), 64'd1);
        check("d", 64'(d), 64'(expect_d(op)));
        check("ovf", 64'(ovf), 64'(op == 32'hFFFF_FFFF));
        check("d_id", 64'(d_id), 64'(w));
        check("gnt_hold", 64'(gnt), 64'(1 << w));
        @(posedge Clk); #1;
        check("gnt_fall", 64'(gnt), 64'd0);
        check("dv_fall", 64'(d_valid), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
        m_ptr = (w + 1) % NREQ;
    endtask

    initial begin
        int w;
        int fair_exp[5] = '{0, 1, 2, 3, 0};

        Rst_n  = 1'b0;
        req    = '0;
        a_flat = '0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_inc_a", 64'(inc_a), 64'd0);
        check("rst_d", 64'(d), 64'd0);
        check("rst_dv", 64'(d_valid), 64'd0);
        check("rst_id", 64'(d_id), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge Clk);
        Rst_n = 1'b1;

        repeat (3) begin
            @(posedge Clk); #1;
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_gnt", 64'(gnt), 64'd0);
        end

        // Fairness with every requester asserting
        for (int i = 0; i < NREQ; i++) a_flat[i*DW +: DW] = 32'(i);
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            run_op(0, w);
            check("fair_order", 64'(w), 64'(fair_exp[n]));
        end

        // Single requester
        req = 4'b0010;
        a_flat[1*DW +: DW] = 32'h0000_0010;
        run_op(0, w);
        check("single_d", 64'(d), 64'h11);

        // Pointer wrap
        req = 4'b1000;
        run_op(0, w);
        req = 4'b1001;
        run_op(0, w);
        check("wrap_first", 64'(w), 64'd0);
        run_op(0, w);
        check("wrap_second", 64'(w), 64'd3);

        // Overflow on requester 2
        req = 4'b0100;
        a_flat[2*DW +: DW] = 32'hFFFF_FFFF;
        run_op(0, w);
        check("ovf_flag", 64'(ovf), 64'd1);

        // Operand latched at grant
        req = 4'b0001;
        a_flat[0 +: DW] = 32'd5;
        run_op(2, w);
        check("stable_d", 64'(d), 64'd6);

        // Randomized traffic, including withdrawn requests and overflow operands
        for (int n = 0; n < 40; n++) begin
            req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++)
                a_flat[i*DW +: DW] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            run_op(n % 2, w);
        end

        // Reset during ISSUE: leave ptr at 3 first so a stale pointer would pick 3 afterwards
        req = 4'b0100;
        run_op(0, w);
        req = 4'b1000;
        @(posedge Clk); #3;
        Rst_n = 1'b0;
        #1;
        check("mid_rst_gnt", 64'(gnt), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        @(posedge Clk); #1;
        check("mid_rst_dv", 64'(d_valid), 64'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        m_ptr = 0;
        req = 4'b1100;
        run_op(0, w);
        check("post_rst_win", 64'(w), 64'd2);
        req = 4'b0100;
        run_op(0, w);
        check("post_rst_single", 64'(w), 64'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
